// File: rtl/sd_spi_responder.sv
// SD-card side SPI mode-0 target: oversamples SCS/SCLK/MOSI on CLKX4, shifts bytes both ways, frames 6-byte commands.
// Pin-to-action latency is 3 CLKX4 edges; a response byte is taken from a one-deep holding register at each byte boundary.
module sd_spi_responder #(
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic        CLKX4,
    input  logic        RESET,
    input  logic        SCS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    output logic [7:0]  RX_DATA,
    output logic        RX_VALID,
    input  logic [7:0]  TX_DATA,
    input  logic        TX_LOAD,
    output logic        TX_READY,
    output logic        CMD_VALID,
    output logic [5:0]  CMD_INDEX,
    output logic [31:0] CMD_ARG,
    output logic        CMD_CRC_OK
);
    typedef enum logic [1:0] {F_IDLE, F_ARG, F_CRC} frame_state_t;

    logic [2:0]   scs_sync_q, sclk_sync_q, mosi_sync_q;
    logic         scs_fall, scs_rise, sclk_rise, sclk_fall, mosi_s2, consume;
    logic         sel_q, sel_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   rx_shift_q, rx_shift_d;
    logic [7:0]   tx_shift_q, tx_shift_d;
    logic [7:0]   hold_q, hold_d;
    logic         tx_ready_q, tx_ready_d;
    logic         miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic         rx_done_q, rx_done_d, rx_valid_q;
    frame_state_t state_q, state_d;
    logic [1:0]   arg_cnt_q, arg_cnt_d;
    logic [5:0]   idx_acc_q, idx_acc_d;
    logic [31:0]  arg_acc_q, arg_acc_d;
    logic [6:0]   crc_acc_q, crc_acc_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic [5:0]   cmd_index_q, cmd_index_d;
    logic [31:0]  cmd_arg_q, cmd_arg_d;
    logic         cmd_crc_ok_q, cmd_crc_ok_d;

    // Bitwise CRC7 (x^7+x^3+1) update, one byte MSB first.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic [7:0] b);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ b[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign scs_fall  = !scs_sync_q[1] &&  scs_sync_q[2];
    assign scs_rise  =  scs_sync_q[1] && !scs_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] && !sclk_sync_q[2];
    assign sclk_fall = !sclk_sync_q[1] &&  sclk_sync_q[2];
    assign mosi_s2   = mosi_sync_q[1];

    always_comb begin
        sel_d      = sel_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        tx_ready_d = tx_ready_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        consume    = 1'b0;
        if (scs_fall) begin
            sel_d     = 1'b1;
            bit_cnt_d = 3'd0;
            miso_oe_d = 1'b1;
            consume   = 1'b1;
        end else if (scs_rise) begin
            sel_d     = 1'b0;
            bit_cnt_d = 3'd0;
            miso_oe_d = 1'b0;
        end else if (sel_q && sclk_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s2};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                rx_data_d = {rx_shift_q[6:0], mosi_s2};
                rx_done_d = 1'b1;
            end
        end else if (sel_q && sclk_fall) begin
            // A fall with the counter wrapped to zero closes the byte.
            if (bit_cnt_q == 3'd0) begin
                consume = 1'b1;
            end else begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
                miso_d     = tx_shift_q[6];
            end
        end
        if (consume) begin
            tx_shift_d = tx_ready_q ? IDLE_BYTE : hold_q;
            miso_d     = tx_ready_q ? IDLE_BYTE[7] : hold_q[7];
        end
        // A load is accepted only into an empty register, even when that register is being consumed this cycle.
        if (consume && !tx_ready_q) begin
            tx_ready_d = 1'b1;
        end else if (TX_LOAD && tx_ready_q) begin
            hold_d     = TX_DATA;
            tx_ready_d = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        arg_cnt_d    = arg_cnt_q;
        idx_acc_d    = idx_acc_q;
        arg_acc_d    = arg_acc_q;
        crc_acc_d    = crc_acc_q;
        cmd_valid_d  = 1'b0;
        cmd_index_d  = cmd_index_q;
        cmd_arg_d    = cmd_arg_q;
        cmd_crc_ok_d = cmd_crc_ok_q;
        if (scs_rise) begin
            state_d = F_IDLE;
        end else if (rx_valid_q) begin
            case (state_q)
                F_IDLE: begin
                    if (rx_data_q[7:6] == 2'b01) begin
                        idx_acc_d = rx_data_q[5:0];
                        crc_acc_d = crc7_next(7'd0, rx_data_q);
                        arg_cnt_d = 2'd0;
                        state_d   = F_ARG;
                    end
                end
                F_ARG: begin
                    arg_acc_d = {arg_acc_q[23:0], rx_data_q};
                    crc_acc_d = crc7_next(crc_acc_q, rx_data_q);
                    arg_cnt_d = arg_cnt_q + 2'd1;
                    if (arg_cnt_q == 2'd3) state_d = F_CRC;
                end
                F_CRC: begin
                    cmd_valid_d  = 1'b1;
                    cmd_index_d  = idx_acc_q;
                    cmd_arg_d    = arg_acc_q;
                    cmd_crc_ok_d = (rx_data_q[7:1] == crc_acc_q) && rx_data_q[0];
                    state_d      = F_IDLE;
                end
                default: state_d = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            scs_sync_q   <= 3'b111;
            sclk_sync_q  <= 3'b000;
            mosi_sync_q  <= 3'b111;
            sel_q        <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 8'd0;
            tx_shift_q   <= IDLE_BYTE;
            hold_q       <= 8'd0;
            tx_ready_q   <= 1'b1;
            miso_q       <= 1'b1;
            miso_oe_q    <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_done_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            state_q      <= F_IDLE;
            arg_cnt_q    <= 2'd0;
            idx_acc_q    <= 6'd0;
            arg_acc_q    <= 32'd0;
            crc_acc_q    <= 7'd0;
            cmd_valid_q  <= 1'b0;
            cmd_index_q  <= 6'd0;
            cmd_arg_q    <= 32'd0;
            cmd_crc_ok_q <= 1'b0;
        end else begin
            scs_sync_q   <= {scs_sync_q[1:0], SCS};
            sclk_sync_q  <= {sclk_sync_q[1:0], SCLK};
            mosi_sync_q  <= {mosi_sync_q[1:0], MOSI};
            sel_q        <= sel_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            tx_ready_q   <= tx_ready_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            rx_valid_q   <= rx_done_q;
            state_q      <= state_d;
            arg_cnt_q    <= arg_cnt_d;
            idx_acc_q    <= idx_acc_d;
            arg_acc_q    <= arg_acc_d;
            crc_acc_q    <= crc_acc_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_index_q  <= cmd_index_d;
            cmd_arg_q    <= cmd_arg_d;
            cmd_crc_ok_q <= cmd_crc_ok_d;
        end
    end

    assign MISO       = miso_q;
    assign MISO_oe    = miso_oe_q;
    assign RX_DATA    = rx_data_q;
    assign RX_VALID   = rx_valid_q;
    assign TX_READY   = tx_ready_q;
    assign CMD_VALID  = cmd_valid_q;
    assign CMD_INDEX  = cmd_index_q;
    assign CMD_ARG    = cmd_arg_q;
    assign CMD_CRC_OK = cmd_crc_ok_q;
endmodule
